// File: rtl/q2_panel_if.sv
// Front-panel signal bundle between the raw switch wiring / core and q2_panel.
interface q2_panel_if;
  logic [11:0] raw_sw;
  logic        raw_incp;
  logic        raw_dep;
  logic        raw_start;
  logic        raw_stop;
  logic        run;
  logic [11:0] sw;
  logic        incp_sw;
  logic        dep_sw;
  logic        start_sw;
  logic        stop_sw;
  logic        busy;

  // Switch/core side: drives raw inputs and run, consumes conditioned outputs.
  modport master (
    output raw_sw, raw_incp, raw_dep, raw_start, raw_stop, run,
    input  sw, incp_sw, dep_sw, start_sw, stop_sw, busy
  );

  // Conditioner side.
  modport slave (
    input  raw_sw, raw_incp, raw_dep, raw_start, raw_stop, run,
    output sw, incp_sw, dep_sw, start_sw, stop_sw, busy
  );
endinterface

// File: rtl/q2_panel.sv
// q2 front-panel conditioner: synchronises and debounces 12 data toggles and
// four momentary buttons, then turns button presses into single, prioritised,
// run-qualified one-clock strobes with a lockout until all buttons release.
module q2_panel #(
  parameter int DEBOUNCE_CYCLES = 500,
  parameter int CNT_W           = 10
) (
  input logic        clk,
  input logic        rst,
  q2_panel_if.slave  pnl
);

  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);

  typedef enum logic {
    IDLE,
    HELD
  } state_t;

  // Bits 11:0 data toggles, 12 incp, 13 dep, 14 start, 15 stop.
  logic [15:0]      raw_all;
  logic [15:0]      sync1;
  logic [15:0]      sync2;
  logic [15:0]      db;
  logic [CNT_W-1:0] cnt [16];

  logic   db_incp, db_dep, db_start, db_stop, any_btn;
  state_t state_q, state_d;
  logic   incp_q, dep_q, start_q, stop_q;
  logic   incp_d, dep_d, start_d, stop_d;

  assign raw_all = {pnl.raw_stop, pnl.raw_start, pnl.raw_dep, pnl.raw_incp, pnl.raw_sw};

  // Two-flop synchroniser for every asynchronous panel input.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1 <= '0;
      sync2 <= '0;
    end else begin
      sync1 <= raw_all;
      sync2 <= sync1;
    end
  end

  // Per-input debounce: a new level must persist DEBOUNCE_CYCLES samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      db <= '0;
      for (int unsigned i = 0; i < 16; i++) cnt[i] <= '0;
    end else begin
      for (int unsigned i = 0; i < 16; i++) begin
        if (sync2[i] == db[i]) begin
          cnt[i] <= '0;
        end else if (cnt[i] == CNT_LAST) begin
          db[i]  <= sync2[i];
          cnt[i] <= '0;
        end else begin
          cnt[i] <= cnt[i] + 1'b1;
        end
      end
    end
  end

  assign db_incp  = db[12];
  assign db_dep   = db[13];
  assign db_start = db[14];
  assign db_stop  = db[15];
  assign any_btn  = db_incp | db_dep | db_start | db_stop;

  // Button arbiter next state and strobe selection; run qualifies the winner
  // but a suppressed press still locks out until release.
  always_comb begin
    state_d = state_q;
    incp_d  = 1'b0;
    dep_d   = 1'b0;
    start_d = 1'b0;
    stop_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (any_btn) begin
          state_d = HELD;
          if (db_stop)       stop_d  = pnl.run;
          else if (db_start) start_d = !pnl.run;
          else if (db_dep)   dep_d   = !pnl.run;
          else               incp_d  = !pnl.run;
        end
      end
      HELD: begin
        if (!any_btn) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM state and registered strobes.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      incp_q  <= 1'b0;
      dep_q   <= 1'b0;
      start_q <= 1'b0;
      stop_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      incp_q  <= incp_d;
      dep_q   <= dep_d;
      start_q <= start_d;
      stop_q  <= stop_d;
    end
  end

  assign pnl.sw       = db[11:0];
  assign pnl.incp_sw  = incp_q;
  assign pnl.dep_sw   = dep_q;
  assign pnl.start_sw = start_q;
  assign pnl.stop_sw  = stop_q;
  assign pnl.busy     = (state_q == HELD);

endmodule

// File: tb/tb_q2_panel.sv
// Directed bench for q2_panel with DEBOUNCE_CYCLES=4: hand-computed timing of
// debounced levels, strobes and lockout relative to each input change.
module tb_q2_panel;

  logic clk = 1'b0;
  logic rst;
  int   n_checks = 0;
  int   n_pass   = 0;

  q2_panel_if pnl ();

  q2_panel #(.DEBOUNCE_CYCLES(4), .CNT_W(3)) dut (
    .clk (clk),
    .rst (rst),
    .pnl (pnl)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
  endtask

  // Advance one clock; outputs are sampled 1 ns after the edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [3:0] strb();
    return {pnl.stop_sw, pnl.start_sw, pnl.dep_sw, pnl.incp_sw};
  endfunction

  task automatic release_all_and_settle();
    pnl.raw_incp  = 1'b0;
    pnl.raw_dep   = 1'b0;
    pnl.raw_start = 1'b0;
    pnl.raw_stop  = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("settle strobes k=%0d", k), 32'(strb()), 32'h0);
    end
    check("settle busy", 32'(pnl.busy), 32'h0);
  endtask

  initial begin
    rst           = 1'b1;
    pnl.raw_sw    = '0;
    pnl.raw_incp  = 1'b0;
    pnl.raw_dep   = 1'b0;
    pnl.raw_start = 1'b0;
    pnl.raw_stop  = 1'b0;
    pnl.run       = 1'b0;

    // Reset and idle.
    repeat (3) tick();
    rst = 1'b0;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("idle k=%0d", k), {15'h0, pnl.sw, strb(), pnl.busy}, 32'h0);
    end

    // Data switches: 6-clock latency, 2-clock glitch rejected.
    pnl.raw_sw = 12'hA5C;
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("sw rise k=%0d", k), 32'(pnl.sw), (k >= 6) ? 32'hA5C : 32'h0);
    end
    pnl.raw_sw = 12'h000;
    tick();
    tick();
    pnl.raw_sw = 12'hA5C;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("sw glitch k=%0d", k), 32'(pnl.sw), 32'hA5C);
      check($sformatf("sw glitch strobes k=%0d", k), 32'(strb()), 32'h0);
    end

    // Start press with run=0: strobe at clock 7, busy until 6 clocks after release.
    pnl.run       = 1'b0;
    pnl.raw_start = 1'b1;
    for (int k = 1; k <= 20; k++) begin
      tick();
      check($sformatf("start strobes k=%0d", k), 32'(strb()), (k == 7) ? 32'h4 : 32'h0);
      check($sformatf("start busy k=%0d", k), 32'(pnl.busy), (k >= 7) ? 32'h1 : 32'h0);
    end
    pnl.raw_start = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("start rel strobes k=%0d", k), 32'(strb()), 32'h0);
      check($sformatf("start rel busy k=%0d", k), 32'(pnl.busy), (k <= 6) ? 32'h1 : 32'h0);
    end

    // Bouncing deposit: last settle is applied before edge 5, strobe at edge 11.
    pnl.raw_dep = 1'b1; tick();
    pnl.raw_dep = 1'b0; tick();
    pnl.raw_dep = 1'b1; tick();
    pnl.raw_dep = 1'b0; tick();
    pnl.raw_dep = 1'b1;
    for (int k = 5; k <= 18; k++) begin
      tick();
      check($sformatf("dep bounce k=%0d", k), 32'(strb()), (k == 11) ? 32'h2 : 32'h0);
    end
    release_all_and_settle();

    // run=1, stop+start together: only stop; start outlasting stop never strobes.
    pnl.run       = 1'b1;
    pnl.raw_stop  = 1'b1;
    pnl.raw_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("stop+start k=%0d", k), 32'(strb()), (k == 7) ? 32'h8 : 32'h0);
    end
    pnl.raw_stop = 1'b0;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("start after stop k=%0d", k), 32'(strb()), 32'h0);
      check($sformatf("start after stop busy k=%0d", k), 32'(pnl.busy), 32'h1);
    end
    release_all_and_settle();

    // incp with run=1 suppressed but locks out; with run=0 strobes once.
    pnl.raw_incp = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("incp run1 k=%0d", k), 32'(strb()), 32'h0);
      check($sformatf("incp run1 busy k=%0d", k), 32'(pnl.busy), (k >= 7) ? 32'h1 : 32'h0);
    end
    release_all_and_settle();
    pnl.run      = 1'b0;
    pnl.raw_incp = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("incp run0 k=%0d", k), 32'(strb()), (k == 7) ? 32'h1 : 32'h0);
    end
    release_all_and_settle();

    // Reset while HELD with start still held: lockout cleared, press re-debounces.
    pnl.raw_start = 1'b1;
    for (int k = 1; k <= 10; k++) begin
      tick();
      check($sformatf("pre-rst start k=%0d", k), 32'(strb()), (k == 7) ? 32'h4 : 32'h0);
    end
    check("pre-rst busy", 32'(pnl.busy), 32'h1);
    rst = 1'b1;
    tick();
    check("rst busy", 32'(pnl.busy), 32'h0);
    check("rst strobes", 32'(strb()), 32'h0);
    check("rst sw", 32'(pnl.sw), 32'h0);
    rst = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      tick();
      check($sformatf("post-rst start k=%0d", k), 32'(strb()), (k == 7) ? 32'h4 : 32'h0);
    end
    check("post-rst busy", 32'(pnl.busy), 32'h1);
    check("post-rst sw", 32'(pnl.sw), 32'hA5C);
    release_all_and_settle();

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/q2_panel.md
Name: q2_panel

Overview:
- Front-panel conditioner that sits between the raw mechanical switches and the q2 core.
- Produces the core's panel inputs: a clean 12-bit data word `sw` and single-cycle strobes `incp_sw`, `dep_sw`, `start_sw` and `stop_sw`.
- Raw inputs are synchronised, debounced and arbitrated, so the core sees at most one strobe per physical press.
- `run` comes back from the core and qualifies the start and stop strobes.

Parameters:
- DEBOUNCE_CYCLES, 500, clocks an input must hold a new level before it is accepted (10 ms at 50 kHz).
- CNT_W, 10, width of each debounce counter; must satisfy 2^CNT_W > DEBOUNCE_CYCLES.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous, active-high reset.
- raw_sw  in  12  raw data toggle switches, asynchronous.
- raw_incp  in  1  raw momentary "increment PC" button, asynchronous, high = pressed.
- raw_dep  in  1  raw momentary "deposit" button, asynchronous.
- raw_start  in  1  raw momentary "start" button, asynchronous.
- raw_stop  in  1  raw momentary "stop" button, asynchronous.
- run  in  1  core running flag.
- sw  out  12  debounced data switches (level).
- incp_sw  out  1  one-clock increment-PC strobe.
- dep_sw  out  1  one-clock deposit strobe.
- start_sw  out  1  one-clock start strobe.
- stop_sw  out  1  one-clock stop strobe.
- busy  out  1  high while a button press is locked out awaiting release.

Behaviour:
- Reset (synchronous): clears all synchronizer flops, debounce counters and debounced levels to 0.
  - Outputs after reset: sw=0, all strobes 0, busy=0, FSM=IDLE.
  - A reset asserted mid-press returns to IDLE. The held button must then re-debounce from 0: a button still held after reset produces a strobe after debounce, because its debounced level rises from 0.
- Synchronisation: each of the 16 raw inputs passes through a 2-flop synchronizer.
- Debounce, one counter per input:
  - If the synced value equals the debounced level, the counter clears.
  - Otherwise the counter increments. When it reaches DEBOUNCE_CYCLES-1, the debounced level takes the synced value and the counter clears.
  - Any glitch back to the old level before then resets the counter.
  - Latency from raw edge to debounced change is exactly DEBOUNCE_CYCLES+2 clocks for a clean edge.
- `sw` equals the debounced data levels directly; no edge detection applies to data switches.
- Button FSM runs on the debounced button levels (db_incp, db_dep, db_start, db_stop):
  - IDLE: waits for any debounced button to be high.
    - Selects one button by priority stop > start > dep > incp.
    - Asserts the selected strobe, subject to qualification, combinationally-registered for exactly one clock, in the cycle after the debounced rise.
    - Goes to HELD.
  - HELD: busy=1; no strobes. Returns to IDLE once all four debounced buttons are low.
  - Simultaneous presses yield only the highest-priority strobe.
  - Presses occurring while in HELD never strobe, even if they are released later.
- Qualification:
  - start_sw is suppressed when run=1.
  - stop_sw is suppressed when run=0.
  - incp_sw and dep_sw are suppressed when run=1.
  - A suppressed press still enters HELD, so no strobe fires later for the same press.
  - `run` is sampled in the same cycle the FSM leaves IDLE.
- Strobes are mutually exclusive: at most one of the four is high in any cycle.
- Strobes are registered outputs.
- Counter widths never wrap: the counter saturates at DEBOUNCE_CYCLES-1 by construction.

Test Plan (DEBOUNCE_CYCLES=4):
- Reset then idle → sw=0, all strobes 0, busy=0 for 20 clocks.
- raw_sw=12'hA5C held; rst low → sw becomes 12'hA5C exactly 6 clocks after the change. A 2-clock pulse to 12'h000 then produces no change on sw.
- run=0, raw_start high for 20 clocks then low → start_sw high for exactly 1 clock, 7 clocks after the press. busy stays high until 6 clocks after release; no second strobe.
- run=0, raw_dep bouncing (1,0,1,0,1 per clock, then steady 1) → exactly one dep_sw pulse, after the steady level has held 4 clocks.
- run=1, raw_stop and raw_start pressed in the same cycle → only stop_sw pulses. Start held past stop's release and then released → no start_sw.
- run=1, raw_incp pressed → no incp_sw; busy=1 until release. Then run=0 and raw_incp pressed again → one incp_sw.
- rst asserted while in HELD with raw_start held, run=0 → busy=0 the next clock. One start_sw follows after re-debounce.
